// File: rtl/temp_calc_mc_if.sv
// Stream and configuration bundle for temp_calc_mc: config write port,
// sample input (valid/ready) and tagged result output (valid/ready).
interface temp_calc_mc_if #(
    parameter int CH_W  = 2,
    parameter int ADC_W = 16,
    parameter int REF_W = 8,
    parameter int OUT_W = 32
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [OUT_W-1:0] cfg_base;
    logic [REF_W-1:0] cfg_ref;

    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic [ADC_W-1:0] in_data;

    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [OUT_W-1:0] out_tempc;
    logic             out_ovf;
    logic             out_err;

    // Producer side: ADC sequencer / configuration master / result consumer.
    modport master (
        output cfg_we, cfg_ch, cfg_base, cfg_ref,
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_tempc, out_ovf, out_err
    );

    // Block side: the temperature calculator itself.
    modport slave (
        input  cfg_we, cfg_ch, cfg_base, cfg_ref,
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_tempc, out_ovf, out_err
    );
endinterface

// File: rtl/temp_calc_mc.sv
// Multi-channel temperature calculator: tempc = tc_base[ch] + in_data * tc_ref[ch].
// One transaction in flight; the multiply is an LSB-first serial shift-add
// over REF_W cycles, followed by an add/saturate cycle and a held output.
module temp_calc_mc #(
    parameter int CHANNELS = 4,
    parameter int ADC_W    = 16,
    parameter int REF_W    = 8,
    parameter int OUT_W    = 32,
    parameter bit SATURATE = 1'b1,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic           clk,
    input logic           rst_n,
    temp_calc_mc_if.slave bus
);
    localparam int CNT_W = $clog2(REF_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] cfg_base_q [CHANNELS];
    logic [OUT_W-1:0] cfg_base_d [CHANNELS];
    logic [REF_W-1:0] cfg_ref_q  [CHANNELS];
    logic [REF_W-1:0] cfg_ref_d  [CHANNELS];

    // Transaction snapshot and serial multiplier state.
    logic [OUT_W-1:0] base_s_q, base_s_d;
    logic [REF_W-1:0] ref_sh_q, ref_sh_d;
    logic [OUT_W-1:0] mcand_q, mcand_d;
    logic [OUT_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             err_q, err_d;

    // Registered result port.
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [OUT_W-1:0] out_tempc_q, out_tempc_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;

    logic             in_ready;
    logic             ch_ok;
    logic [OUT_W:0]   sum;

    assign in_ready      = (state_q == IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_tempc = out_tempc_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;

    // Configuration register file: single-cycle writes, out-of-range channel ignored.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cfg_base_d = cfg_base_q;
        cfg_ref_d  = cfg_ref_q;
        if (bus.cfg_we && (32'(bus.cfg_ch) < CHANNELS)) begin
            cfg_base_d[bus.cfg_ch] = bus.cfg_base;
            cfg_ref_d[bus.cfg_ch]  = bus.cfg_ref;
        end
    end

    // Next-state and datapath for the IDLE -> MUL -> ADD -> OUT sequence.
    always_comb begin
        state_d     = state_q;
        base_s_d    = base_s_q;
        ref_sh_d    = ref_sh_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_tempc_d = out_tempc_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        ch_ok       = (32'(bus.in_ch) < CHANNELS);
        sum         = {1'b0, base_s_q} + {1'b0, prod_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    // Snapshot reads the pre-write config, so a same-edge write is not seen.
                    base_s_d = ch_ok ? cfg_base_q[bus.in_ch] : '0;
                    ref_sh_d = ch_ok ? cfg_ref_q[bus.in_ch]  : '0;
                    mcand_d  = OUT_W'(bus.in_data);
                    prod_d   = '0;
                    cnt_d    = '0;
                    ch_d     = bus.in_ch;
                    err_d    = !ch_ok;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (ref_sh_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                ref_sh_d = ref_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(REF_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                out_ch_d    = ch_q;
                out_ovf_d   = sum[OUT_W];
                out_err_d   = err_q;
                out_tempc_d = (SATURATE && sum[OUT_W]) ? '1 : sum[OUT_W-1:0];
                state_d     = OUT;
            end
            OUT: begin
                // out_valid rises one cycle into OUT and falls on the handshake edge.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the config file is reset too, because reset must clear every channel's base/ref.
            for (int i = 0; i < CHANNELS; i++) begin
                cfg_base_q[i] <= '0;
                cfg_ref_q[i]  <= '0;
            end
            state_q     <= IDLE;
            base_s_q    <= '0;
            ref_sh_q    <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_tempc_q <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            cfg_base_q  <= cfg_base_d;
            cfg_ref_q   <= cfg_ref_d;
            state_q     <= state_d;
            base_s_q    <= base_s_d;
            ref_sh_q    <= ref_sh_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_tempc_q <= out_tempc_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: doc/temp_calc_mc.md
Name: temp_calc_mc

Overview:
Multi-channel, sequential successor to the combinational temperature calculator. Each channel has its own programmable base (tc_base) and coefficient (tc_ref) register. Incoming ADC samples arrive over a valid/ready handshake, are multiplied by a serial shift-add unit and added to the channel base, with optional saturation. Results leave on a valid/ready output port tagged with channel id, sitting between the ADC sequencer and the temperature reporting logic.

Parameters:
CHANNELS, 4, number of channels (>=1); channel index width CH_W = max(1, clog2(CHANNELS))
ADC_W, 16, ADC sample width (unsigned)
REF_W, 8, coefficient width (unsigned); also the number of multiply iterations
OUT_W, 32, base/result width; constraint ADC_W+REF_W <= OUT_W
SATURATE, 1, 1: clamp on overflow to all-ones; 0: wrap modulo 2^OUT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel to configure
cfg_base  in  OUT_W  tc_base value for cfg_ch
cfg_ref  in  REF_W  tc_ref value for cfg_ch
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_ch  in  CH_W  sample channel
in_data  in  ADC_W  ADC sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_ch  out  CH_W  channel of result
out_tempc  out  OUT_W  result
out_ovf  out  1  overflow occurred (result clamped or wrapped)
out_err  out  1  sample carried an invalid channel index

Behaviour:
- Reset (async assert, sync-released by the system): all cfg base/ref = 0; state = IDLE; out_valid = 0; out_tempc = 0; out_ch = 0; out_ovf = 0; out_err = 0; product/iteration counters = 0.
- in_ready = (state == IDLE), combinational from the state register, so it reads 1 while in reset.
- Formula: tempc = tc_base[ch] + in_data * tc_ref[ch], computed as unsigned with OUT_W+1 bits internally.
- IDLE: on in_valid && in_ready, capture in_data, in_ch, and a snapshot of that channel's base and ref, then go to MUL.
  - in_ch >= CHANNELS: the sample is accepted, base/ref are treated as 0, and out_err = 1 is carried with the result.
- MUL: runs REF_W cycles of LSB-first shift-add on the ref snapshot, then goes to ADD.
- ADD: one cycle; sum = base + product in OUT_W+1 bits.
  - ovf = sum[OUT_W].
  - Result = all-ones if SATURATE && ovf, otherwise sum[OUT_W-1:0].
  - Registers out_* and goes to OUT.
- OUT: out_valid = 1; out_* are held stable until out_valid && out_ready, then out_valid drops on the next edge and state returns to IDLE.
- Latency: acceptance at edge E gives out_valid high after edge E+REF_W+2.
  - With out_ready tied high, the next sample is accepted at edge E+REF_W+4.
  - Throughput is 1 sample per REF_W+4 cycles.
- Config writes:
  - Accepted in any state in a single cycle.
  - cfg_ch >= CHANNELS is ignored.
  - A write never affects a transaction already accepted (snapshot rule).
  - A write and an acceptance to the same channel on the same edge: the acceptance uses the old value.
- Zero cases: ref = 0 or in_data = 0 gives result = base, ovf = 0. Max operands never overflow the product (guaranteed by the width constraint).
- Reset mid-operation (any state) aborts the transaction immediately: out_valid = 0, config cleared, and no result appears after release.

Test Plan:
- ch1 base=0xAAAAAAAA, ref=0xC6; sample ch1 data=0xAAAA -> out_tempc=0xAB2EAA26, out_ch=1, ovf=0, err=0; out_valid exactly REF_W+2 edges after acceptance.
- ch0 base=0xFFFFFF00, ref=0x01; data=0x0100 -> SATURATE=1: 0xFFFFFFFF, ovf=1; SATURATE=0: 0x00000000, ovf=1.
- ch0 base=10, ref=2; ch3 base=7, ref=0; samples ch3 data=0xFFFF then ch0 data=5 -> results 7 (ch3), then 20 (ch0), in order.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid and out_* stable, in_ready=0, in_valid ignored; release -> one handshake, then in_ready=1.
- Accept ch2 (base=100, ref=3, data=4), then write ch2 ref=9 during MUL -> result 112; next ch2 sample data=4 -> 136.
- Drive rst_n low during MUL -> out_valid=0 and in_ready=1 immediately; after release, no spurious result and all cfg registers read back as 0 via a data=1 sample (result 0).
